mult4_4_ctrl: RTL and testbench

Sequencing controller for the 4x4 shift-and-add multiplier datapath. It sits directly upstream of that datapath and drives the operand-capture, half-select, product-gate and shift-select lines. It steps one 2x2 partial product per cycle into the datapath's 8-bit accumulator, then signals completion. It also keeps a wrapping count of completed multiplies.

---
 rtl/mult4_4_ctrl_if.sv | 28 ++
 rtl/mult4_4_ctrl.sv | 68 ++++++
 tb/tb_mult4_4_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult4_4_ctrl_if.sv
// mult4_4_ctrl_if: control bundle from the requester through the controller to the multiplier datapath.
// When MULT4_4_CTRL_ABORT_EN is defined, the bundle also carries the abort request.
interface mult4_4_ctrl_if #(parameter int CNT_W = 8);
    logic             start;
`ifdef MULT4_4_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             ld;
    logic             acc_clr;
    logic             Asel;
    logic             Bsel;
    logic             mult_sel;
    logic [1:0]       ans_sel;
    logic             done;
    logic [CNT_W-1:0] mul_cnt;
`ifdef MULT4_4_CTRL_ABORT_EN
    modport master (output start, abort,
                    input ready, ld, acc_clr, Asel, Bsel, mult_sel, ans_sel, done, mul_cnt);
    modport slave  (input start, abort,
                    output ready, ld, acc_clr, Asel, Bsel, mult_sel, ans_sel, done, mul_cnt);
`else
    modport master (output start,
                    input ready, ld, acc_clr, Asel, Bsel, mult_sel, ans_sel, done, mul_cnt);
    modport slave  (input start,
                    output ready, ld, acc_clr, Asel, Bsel, mult_sel, ans_sel, done, mul_cnt);
`endif
endinterface

// File: rtl/mult4_4_ctrl.sv
// mult4_4_ctrl: sequencing controller stepping the 4x4 shift-and-add datapath through four 2x2 partial products.
// Define MULT4_4_CTRL_ABORT_EN to add an abort request that cancels a multiply before DONE.
module mult4_4_ctrl #(
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    mult4_4_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, P0, P1, P2, P3, DONE} state_t;
    state_t           state;
    state_t           nxt;
    logic             run;
    logic             abort_i;
    logic [CNT_W-1:0] cnt;
`ifdef MULT4_4_CTRL_ABORT_EN
    assign abort_i = bus.abort;
`else
    assign abort_i = 1'b0;
`endif
    assign bus.mul_cnt = cnt;
    // Reset release passes through one flop, so the FSM can first move on the second edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end
    // Next state: fixed walk LOAD..DONE, start only honoured in IDLE, abort drops a running sequence to IDLE
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? LOAD : IDLE;
            LOAD:    nxt = P0;
            P0:      nxt = P1;
            P1:      nxt = P2;
            P2:      nxt = P3;
            P3:      nxt = DONE;
            default: nxt = IDLE;
        endcase
        if (abort_i && state != IDLE && state != DONE) nxt = IDLE;
        if (!run) nxt = state;
    end
    // State register with Moore outputs registered from the state being entered; count bumps on leaving DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bus.ready    <= 1'b1;
            bus.ld       <= 1'b0;
            bus.acc_clr  <= 1'b0;
            bus.Asel     <= 1'b0;
            bus.Bsel     <= 1'b0;
            bus.mult_sel <= 1'b0;
            bus.ans_sel  <= 2'd0;
            bus.done     <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= nxt;
            bus.ready    <= nxt == IDLE;
            bus.ld       <= nxt == LOAD;
            bus.acc_clr  <= nxt == LOAD;
            bus.Asel     <= nxt == P2 || nxt == P3;
            bus.Bsel     <= nxt == P1 || nxt == P3;
            bus.mult_sel <= nxt == P0 || nxt == P1 || nxt == P2 || nxt == P3;
            bus.ans_sel  <= nxt == P0 ? 2'd3 : (nxt == P1 || nxt == P2) ? 2'd2 : nxt == P3 ? 2'd1 : 2'd0;
            bus.done     <= nxt == DONE;
            if (run && state == DONE) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mult4_4_ctrl.sv
// tb_mult4_4_ctrl: self-checking bench for mult4_4_ctrl with a behavioural datapath and a timeline reference model.
// Builds with or without MULT4_4_CTRL_ABORT_EN; abort scenarios are exercised only when it is defined.
module tb_mult4_4_ctrl;
`ifdef MULT4_4_CTRL_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif
    // Control word order: ready, ld, acc_clr, Asel, Bsel, mult_sel, ans_sel[1:0], done
    typedef struct packed {
        logic       ready;
        logic       ld;
        logic       acc_clr;
        logic       asel;
        logic       bsel;
        logic       msel;
        logic [1:0] ans;
        logic       done;
    } ctl_t;
    typedef struct {
        logic start;
        ctl_t exp;
    } vec_t;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } dp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [3:0] in1 = 4'd0;
    logic [3:0] in2 = 4'd0;
    always #5 clk = ~clk;

    mult4_4_ctrl_if #(.CNT_W(8)) bus ();
    mult4_4_ctrl_if #(.CNT_W(2)) bus2 ();
    mult4_4_ctrl #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    mult4_4_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus.start  = start;
    assign bus2.start = start;
`ifdef MULT4_4_CTRL_ABORT_EN
    assign bus.abort  = abort;
    assign bus2.abort = abort;
`endif

    ctl_t c1, c2;
    assign c1 = {bus.ready, bus.ld, bus.acc_clr, bus.Asel, bus.Bsel, bus.mult_sel, bus.ans_sel, bus.done};
    assign c2 = {bus2.ready, bus2.ld, bus2.acc_clr, bus2.Asel, bus2.Bsel, bus2.mult_sel, bus2.ans_sel, bus2.done};

    // Behavioural 4x4 shift-and-add datapath driven by the first controller
    logic [3:0] a_r = 4'd0;
    logic [3:0] b_r = 4'd0;
    logic [7:0] acc = 8'd0;
    logic [1:0] ah, bh;
    logic [3:0] pp;
    logic [7:0] addend;
    assign ah = bus.Asel ? a_r[3:2] : a_r[1:0];
    assign bh = bus.Bsel ? b_r[3:2] : b_r[1:0];
    assign pp = bus.mult_sel ? {2'd0, ah} * {2'd0, bh} : 4'd0;
    assign addend = bus.ans_sel == 2'd1 ? {pp, 4'd0} : bus.ans_sel == 2'd2 ? {2'd0, pp, 2'd0} :
                    bus.ans_sel == 2'd3 ? {4'd0, pp} : 8'd0;
    always_ff @(posedge clk) begin
        if (bus.ld) begin
            a_r <= in1;
            b_r <= in2;
        end
        acc <= bus.acc_clr ? 8'd0 : acc + addend;
    end

    // Reference model: pos = cycles since an accepted start (0 = idle, 1 = LOAD ... 6 = DONE)
    ctl_t phase_tab [7];
    int pos = 0;
    int cnt = 0;
    int prod = 0;
    bit hold = 1'b1;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            pos = 0;
            cnt = 0;
            hold = 1'b1;
        end else if (hold) hold = 1'b0;
        else if (pos == 0) pos = start ? 1 : 0;
        else if (pos == 6) begin
            pos = 0;
            cnt++;
        end else if (ABORT && abort) pos = 0;
        else begin
            if (pos == 1) prod = int'(in1) * int'(in2);
            pos++;
        end
    endtask

    task automatic compare();
        chk("ctl", 16'(c1), 16'(phase_tab[pos]));
        chk("mul_cnt", 16'(bus.mul_cnt), 16'(cnt % 256));
        chk("ctl_w2", 16'(c2), 16'(phase_tab[pos]));
        chk("mul_cnt_w2", 16'(bus2.mul_cnt), 16'(cnt % 4));
        if (pos == 6) chk("acc_model", 16'(acc), 16'(prod));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        pos = 0;
        cnt = 0;
        hold = 1'b1;
        compare();
        #1;
        rst = 1'b1;
    endtask

    task automatic run_one();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!seen && n < 10) begin
            step();
            n++;
            if (c1.done) seen = 1'b1;
        end
        chk("done_seen", 16'(seen), 16'd1);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t seq [7];
        dp_t dp [3];
        int wrap_tab [5];
        int done_cyc [$];
        int n;
        int dcount;
        phase_tab[0] = 9'b1_0_0_0_0_0_00_0;
        phase_tab[1] = 9'b0_1_1_0_0_0_00_0;
        phase_tab[2] = 9'b0_0_0_0_0_1_11_0;
        phase_tab[3] = 9'b0_0_0_0_1_1_10_0;
        phase_tab[4] = 9'b0_0_0_1_0_1_10_0;
        phase_tab[5] = 9'b0_0_0_1_1_1_01_0;
        phase_tab[6] = 9'b0_0_0_0_0_0_00_1;
        seq[0] = '{1'b1, 9'b0_1_1_0_0_0_00_0};
        seq[1] = '{1'b0, 9'b0_0_0_0_0_1_11_0};
        seq[2] = '{1'b0, 9'b0_0_0_0_1_1_10_0};
        seq[3] = '{1'b0, 9'b0_0_0_1_0_1_10_0};
        seq[4] = '{1'b0, 9'b0_0_0_1_1_1_01_0};
        seq[5] = '{1'b0, 9'b0_0_0_0_0_0_00_1};
        seq[6] = '{1'b0, 9'b1_0_0_0_0_0_00_0};
        dp[0] = '{4'hF, 4'hF, 8'hE1};
        dp[1] = '{4'hA, 4'h3, 8'h1E};
        dp[2] = '{4'h0, 4'h9, 8'h00};
        wrap_tab = '{1, 2, 3, 0, 1};

        // Reset held over two edges, then release and idle without start
        step();
        step();
        rst = 1'b1;
        repeat (3) step();

        // Single start pulse against the literal sequence table
        for (int i = 0; i < 7; i++) begin
            start = seq[i].start;
            step();
            chk("seq", 16'(c1), 16'(seq[i].exp));
        end

        // Datapath products read when done is high
        for (int i = 0; i < 3; i++) begin
            in1 = dp[i].a;
            in2 = dp[i].b;
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (!c1.done && n < 10) begin
                step();
                n++;
            end
            chk("dp_acc", 16'(acc), 16'(dp[i].p));
            step();
        end

        // Asynchronous reset in the middle of P2
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("in_p2", 16'(c1), 16'(9'b0_0_0_1_0_1_10_0));
        async_reset();
        chk("rst_mid", 16'(c1), 16'(9'b1_0_0_0_0_0_00_0));
        repeat (3) step();

        // Back-to-back multiplies with start held high
        start = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step();
            if (c1.done) done_cyc.push_back(cyc);
        end
        start = 1'b0;
        chk("b2b_cnt", 16'(bus.mul_cnt), 16'd3);
        chk("b2b_dones", 16'(done_cyc.size()), 16'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_gap1", 16'(done_cyc[1] - done_cyc[0]), 16'd7);
            chk("b2b_gap2", 16'(done_cyc[2] - done_cyc[1]), 16'd7);
        end
        step();

        // Start present at reset release is first acted on at the second edge
        async_reset();
        start = 1'b1;
        step();
        chk("sync_e1", 16'(c1.ready), 16'd1);
        step();
        chk("sync_e2", 16'(c1.ld), 16'd1);
        start = 1'b0;
        repeat (6) step();

        // Counter wrap on the 2-bit instance
        async_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            run_one();
            chk("wrap", 16'(bus2.mul_cnt), 16'(wrap_tab[i]));
        end

        // Abort during P1, then a full multiply, then abort together with start in IDLE
        if (ABORT) begin
            n = cnt;
            dcount = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_idle", 16'(c1.ready), 16'd1);
            for (int i = 0; i < 8; i++) begin
                step();
                if (c1.done) dcount++;
            end
            chk("abort_nodone", 16'(dcount), 16'd0);
            chk("abort_cnt", 16'(bus.mul_cnt), 16'(n % 256));
            run_one();
            chk("after_abort_cnt", 16'(bus.mul_cnt), 16'((n + 1) % 256));
            start = 1'b1;
            abort = 1'b1;
            step();
            start = 1'b0;
            abort = 1'b0;
            chk("start_wins", 16'(c1.ld), 16'd1);
            repeat (7) step();
        end

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            in1 = 4'($urandom);
            in2 = 4'($urandom);
            start = $urandom_range(0, 2) == 0;
            abort = ABORT && $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 99) == 0) async_reset();
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
